// File: rtl/operand_fetch.sv
// operand_fetch -- operand-fetch stage between decode and execute.
//
// Drives the 32x32 register file read addresses straight from the incoming
// instruction, absorbs the file's one-cycle registered read in stage F, and
// hands operand pairs to execute through a 2-entry in-order output FIFO.
// A 32-bit busy scoreboard holds back RAW/WAW hazards against in-flight
// destinations. Writeback data is forwarded both from the accept cycle
// (latched in F) and from the cycle F drains (live).
//
// Optional feature macro: OPERAND_FETCH_WB_BYPASS_EN
//   defined     -> a matching writeback clears the hazard in the same cycle
//                  and the bypass muxes forward its data.
//   not defined -> no early clear and no bypass muxes; a dependent
//                  instruction issues the cycle after writeback and the
//                  register file read returns the new value.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_in_valid / o_in_ready    decoded-instruction handshake
//   i_in_rs1, i_in_rs2         source register numbers
//   i_in_rd, i_in_rd_we        destination register and its write enable
//   i_in_ctrl                  opaque control carried alongside the operands
//   o_r1_add, o_r2_add         register file read addresses (combinational)
//   i_r1_value, i_r2_value     register file read data, one cycle later
//   i_wb_enable/_add/_data     writeback bus (shared with the file write port)
//   i_flush                    synchronous kill of F and the output FIFO
//   o_out_valid / i_out_ready  operand-pair handshake to execute
//   o_out_a, o_out_b           source operands
//   o_out_rd, o_out_rd_we,
//   o_out_ctrl                 fields carried from the instruction
module operand_fetch #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [4:0]        i_in_rs1,
  input  logic [4:0]        i_in_rs2,
  input  logic [4:0]        i_in_rd,
  input  logic              i_in_rd_we,
  input  logic [CTRL_W-1:0] i_in_ctrl,
  output logic [4:0]        o_r1_add,
  output logic [4:0]        o_r2_add,
  input  logic [DATA_W-1:0] i_r1_value,
  input  logic [DATA_W-1:0] i_r2_value,
  input  logic              i_wb_enable,
  input  logic [4:0]        i_wb_add,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic              i_flush,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_a,
  output logic [DATA_W-1:0] o_out_b,
  output logic [4:0]        o_out_rd,
  output logic              o_out_rd_we,
  output logic [CTRL_W-1:0] o_out_ctrl
);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [4:0]        rd;
    logic              rd_we;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  // Stage F: instruction whose register file read is in flight.
  logic              r_f_valid;
  logic [4:0]        r_f_rd;
  logic              r_f_rd_we;
  logic [CTRL_W-1:0] r_f_ctrl;

  // Output FIFO.
  entry_t            r_fifo [0:1];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_count;

  logic [31:0]       r_busy;
  logic [31:0]       w_busy_next;

  logic              w_clr1, w_clr2, w_clrd;
  logic              w_hazard;
  logic              w_deq;
  logic              w_push;
  logic              w_accept;
  logic [2:0]        w_occ_sum;
  logic [2:0]        w_occ_limit;
  logic [DATA_W-1:0] w_op_a, w_op_b;
  logic [1:0]        w_slot_kill;

  assign o_r1_add = i_in_rs1;
  assign o_r2_add = i_in_rs2;

`ifdef OPERAND_FETCH_WB_BYPASS_EN
  // Source numbers and writeback forwarding captured at accept time.
  logic [4:0]        r_f_rs1, r_f_rs2;
  logic              r_f_byp1_valid, r_f_byp2_valid;
  logic [DATA_W-1:0] r_f_byp1_data, r_f_byp2_data;

  assign w_clr1 = i_wb_enable && (i_wb_add == i_in_rs1);
  assign w_clr2 = i_wb_enable && (i_wb_add == i_in_rs2);
  assign w_clrd = i_wb_enable && (i_wb_add == i_in_rd);

  // Live writeback while F drains beats the value latched at accept, which
  // beats the register file read (the file returns its pre-write contents).
  assign w_op_a = (i_wb_enable && (i_wb_add == r_f_rs1)) ? i_wb_data :
                  r_f_byp1_valid ? r_f_byp1_data : i_r1_value;
  assign w_op_b = (i_wb_enable && (i_wb_add == r_f_rs2)) ? i_wb_data :
                  r_f_byp2_valid ? r_f_byp2_data : i_r2_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f_rs1        <= '0;
      r_f_rs2        <= '0;
      r_f_byp1_valid <= 1'b0;
      r_f_byp2_valid <= 1'b0;
      r_f_byp1_data  <= '0;
      r_f_byp2_data  <= '0;
    end else if (w_accept) begin
      r_f_rs1        <= i_in_rs1;
      r_f_rs2        <= i_in_rs2;
      r_f_byp1_valid <= w_clr1;
      r_f_byp2_valid <= w_clr2;
      r_f_byp1_data  <= i_wb_data;
      r_f_byp2_data  <= i_wb_data;
    end
  end
`else
  assign w_clr1 = 1'b0;
  assign w_clr2 = 1'b0;
  assign w_clrd = 1'b0;
  assign w_op_a = i_r1_value;
  assign w_op_b = i_r2_value;

  // Writeback data only feeds the bypass muxes, which are absent here.
  logic w_unused_wb_data;
  assign w_unused_wb_data = ^i_wb_data;
`endif

  assign w_hazard = (r_busy[i_in_rs1] && !w_clr1) ||
                    (r_busy[i_in_rs2] && !w_clr2) ||
                    (i_in_rd_we && r_busy[i_in_rd] && !w_clrd);

  assign o_out_valid = (r_count != 2'd0);
  assign w_deq       = o_out_valid && i_out_ready;
  assign w_push      = r_f_valid && !i_flush;

  // occ + f_valid - deq < 2, rearranged to stay unsigned. The dequeue term
  // makes in_ready depend combinationally on out_ready on purpose: a full
  // buffer can accept in the same cycle it releases an entry.
  assign w_occ_sum   = {1'b0, r_count} + {2'b00, r_f_valid};
  assign w_occ_limit = 3'd2 + {2'b00, w_deq};

  assign o_in_ready = rst_n && !i_flush && !w_hazard && (w_occ_sum < w_occ_limit);
  assign w_accept   = i_in_valid && o_in_ready;

  // A FIFO slot is killed by flush when it holds a live entry that is not
  // being handed to execute this same cycle.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot_kill
      logic w_live;
      assign w_live = (r_count == 2'd2) ||
                      ((r_count == 2'd1) && (r_rd_ptr == 1'(gi)));
      assign w_slot_kill[gi] = i_flush && w_live && r_fifo[gi].rd_we &&
                               !(w_deq && (r_rd_ptr == 1'(gi)));
    end
  endgenerate

  // Scoreboard: clears first, then an accepted writer sets its bit, so a
  // set and clear of the same register in one cycle leaves it busy.
  always_comb begin
    w_busy_next = r_busy;
    if (i_wb_enable) begin
      w_busy_next[i_wb_add] = 1'b0;
    end
    if (i_flush && r_f_valid && r_f_rd_we) begin
      w_busy_next[r_f_rd] = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      if (w_slot_kill[i]) begin
        w_busy_next[r_fifo[i].rd] = 1'b0;
      end
    end
    if (w_accept && i_in_rd_we) begin
      w_busy_next[i_in_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f_valid <= 1'b0;
      r_f_rd    <= '0;
      r_f_rd_we <= 1'b0;
      r_f_ctrl  <= '0;
      r_busy    <= '0;
      r_rd_ptr  <= 1'b0;
      r_wr_ptr  <= 1'b0;
      r_count   <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_fifo[i] <= '0;
      end
    end else begin
      // F holds an instruction for exactly one cycle; flush blocks accept.
      r_f_valid <= w_accept;
      if (w_accept) begin
        r_f_rd    <= i_in_rd;
        r_f_rd_we <= i_in_rd_we;
        r_f_ctrl  <= i_in_ctrl;
      end
      r_busy <= w_busy_next;

      if (i_flush) begin
        r_rd_ptr <= 1'b0;
        r_wr_ptr <= 1'b0;
        r_count  <= 2'd0;
      end else begin
        if (w_push) begin
          r_fifo[r_wr_ptr] <= '{a: w_op_a, b: w_op_b, rd: r_f_rd,
                                rd_we: r_f_rd_we, ctrl: r_f_ctrl};
          r_wr_ptr <= ~r_wr_ptr;
        end
        if (w_deq) begin
          r_rd_ptr <= ~r_rd_ptr;
        end
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_deq};
      end
    end
  end

  assign o_out_a     = r_fifo[r_rd_ptr].a;
  assign o_out_b     = r_fifo[r_rd_ptr].b;
  assign o_out_rd    = r_fifo[r_rd_ptr].rd;
  assign o_out_rd_we = r_fifo[r_rd_ptr].rd_we;
  assign o_out_ctrl  = r_fifo[r_rd_ptr].ctrl;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch -- directed self-checking bench for operand_fetch.
// Contains a behavioural 32x32 register file with registered read
// (read returns pre-write contents) written by the writeback bus.
// Expected output pairs are queued at acceptance and compared on dequeue.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [4:0]  i_in_rs1, i_in_rs2, i_in_rd;
  logic        i_in_rd_we;
  logic [15:0] i_in_ctrl;
  logic [4:0]  o_r1_add, o_r2_add;
  logic [31:0] i_r1_value, i_r2_value;
  logic        i_wb_enable;
  logic [4:0]  i_wb_add;
  logic [31:0] i_wb_data;
  logic        i_flush;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [31:0] o_out_a, o_out_b;
  logic [4:0]  o_out_rd;
  logic        o_out_rd_we;
  logic [15:0] o_out_ctrl;

  operand_fetch #(.DATA_W(32), .CTRL_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_rs1(i_in_rs1), .i_in_rs2(i_in_rs2), .i_in_rd(i_in_rd),
    .i_in_rd_we(i_in_rd_we), .i_in_ctrl(i_in_ctrl),
    .o_r1_add(o_r1_add), .o_r2_add(o_r2_add),
    .i_r1_value(i_r1_value), .i_r2_value(i_r2_value),
    .i_wb_enable(i_wb_enable), .i_wb_add(i_wb_add), .i_wb_data(i_wb_data),
    .i_flush(i_flush),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_a(o_out_a), .o_out_b(o_out_b), .o_out_rd(o_out_rd),
    .o_out_rd_we(o_out_rd_we), .o_out_ctrl(o_out_ctrl)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file model.
  logic [31:0] rf [0:31];
  always @(posedge clk) begin
    i_r1_value <= rf[o_r1_add];
    i_r2_value <= rf[o_r2_add];
    if (i_wb_enable) rf[i_wb_add] <= i_wb_data;
  end

  function automatic logic [31:0] init_val(input int k);
    case (k)
      0:       return 32'h99;
      3:       return 32'h11;
      4:       return 32'h22;
      7:       return 32'h77;
      8:       return 32'h88;
      10:      return 32'hAA;
      default: return 32'h1000 + k;
    endcase
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic [15:0] ctrl;
  } exp_t;

  exp_t sb[$];
  int   n_out = 0;
  int   out_cyc [0:63];

  // Output monitor: every dequeue is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && o_out_valid && i_out_ready) begin
      if (n_out < 64) out_cyc[n_out] = cyc;
      n_out++;
      if (sb.size() == 0) begin
        check("unexpected_out", 64'(o_out_rd), 64'h3F);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_a", 64'(o_out_a), 64'(e.a));
        check("out_b", 64'(o_out_b), 64'(e.b));
        check("out_rd", 64'(o_out_rd), 64'(e.rd));
        check("out_rd_we", 64'(o_out_rd_we), 64'(e.we));
        check("out_ctrl", 64'(o_out_ctrl), 64'(e.ctrl));
      end
    end
  end

  // Offer one instruction; wait up to max_wait cycles for acceptance.
  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic we,
                       input logic [15:0] ctrl, input logic [31:0] ea,
                       input logic [31:0] eb, input int max_wait,
                       input string tag);
    bit ok;
    exp_t e;
    ok = 1'b0;
    i_in_valid = 1'b1; i_in_rs1 = rs1; i_in_rs2 = rs2;
    i_in_rd = rd; i_in_rd_we = we; i_in_ctrl = ctrl;
    for (int k = 0; k < max_wait; k++) begin
      @(negedge clk);
      if (o_in_ready) begin
        ok = 1'b1;
        e.a = ea; e.b = eb; e.rd = rd; e.we = we; e.ctrl = ctrl;
        sb.push_back(e);
      end
      @(posedge clk); #1;
      if (ok) break;
    end
    i_in_valid = 1'b0;
    check(tag, 64'(ok), 64'd1);
  endtask

  int n0;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_n = 1'b1; i_in_valid = 1'b0; i_in_rs1 = '0; i_in_rs2 = '0;
    i_in_rd = '0; i_in_rd_we = 1'b0; i_in_ctrl = '0; i_wb_enable = 1'b0;
    i_wb_add = '0; i_wb_data = '0; i_flush = 1'b0; i_out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", 64'(o_out_valid), 64'd0);
    check("rst_in_ready", 64'(o_in_ready), 64'd0);
    check("rst_out_a", 64'(o_out_a), 64'd0);
    check("rst_out_b", 64'(o_out_b), 64'd0);
    check("rst_out_rd", 64'(o_out_rd), 64'd0);
    check("rst_out_rd_we", 64'(o_out_rd_we), 64'd0);
    check("rst_out_ctrl", 64'(o_out_ctrl), 64'd0);

    // Preload the register file through the writeback bus while in reset.
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      i_wb_enable = 1'b1; i_wb_add = 5'(k); i_wb_data = init_val(k);
    end
    @(posedge clk); #1;
    i_wb_enable = 1'b0;
    check("rst_in_ready_held", 64'(o_in_ready), 64'd0);
    rst_n = 1'b1;
    i_out_ready = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(o_in_ready), 64'd1);
    @(posedge clk); #1;

    // Basic read and two-cycle latency.
    issue(5'd3, 5'd4, 5'd5, 1'b0, 16'h0001, 32'h11, 32'h22, 4, "t1_accept");
    @(negedge clk);
    check("t1_valid_c1", 64'(o_out_valid), 64'd0);
    @(negedge clk);
    check("t1_valid_c2", 64'(o_out_valid), 64'd1);
    @(posedge clk); #1;
    repeat (2) @(posedge clk); #1;

    // RAW stall on R5 resolved by writeback of 0xDEAD.
    issue(5'd0, 5'd0, 5'd5, 1'b1, 16'h0002, 32'h99, 32'h99, 4, "t2_producer");
    i_in_valid = 1'b1; i_in_rs1 = 5'd5; i_in_rs2 = 5'd4;
    i_in_rd = 5'd6; i_in_rd_we = 1'b0; i_in_ctrl = 16'h0003;
    e.a = 32'hDEAD; e.b = 32'h22; e.rd = 5'd6; e.we = 1'b0; e.ctrl = 16'h0003;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t2_stall", 64'(o_in_ready), 64'd0);
      @(posedge clk); #1;
    end
    i_wb_enable = 1'b1; i_wb_add = 5'd5; i_wb_data = 32'hDEAD;
`ifdef OPERAND_FETCH_WB_BYPASS_EN
    @(negedge clk);
    check("t2_accept_wb_cycle", 64'(o_in_ready), 64'd1);
    if (o_in_ready) sb.push_back(e);
    @(posedge clk); #1;
    i_wb_enable = 1'b0; i_in_valid = 1'b0;
`else
    @(negedge clk);
    check("t2_stall_wb_cycle", 64'(o_in_ready), 64'd0);
    @(posedge clk); #1;
    i_wb_enable = 1'b0;
    @(negedge clk);
    check("t2_accept_after_wb", 64'(o_in_ready), 64'd1);
    if (o_in_ready) sb.push_back(e);
    @(posedge clk); #1;
    i_in_valid = 1'b0;
`endif
    repeat (4) @(posedge clk); #1;

    // Backpressure: two held, third waits, in-order drain.
    i_out_ready = 1'b0;
    issue(5'd3, 5'd4, 5'd12, 1'b0, 16'h00A1, 32'h11, 32'h22, 1, "t3_accept_a");
    issue(5'd4, 5'd3, 5'd13, 1'b0, 16'h00B2, 32'h22, 32'h11, 1, "t3_accept_b");
    i_in_valid = 1'b1; i_in_rs1 = 5'd0; i_in_rs2 = 5'd3;
    i_in_rd = 5'd14; i_in_rd_we = 1'b0; i_in_ctrl = 16'h00C3;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t3_third_blocked", 64'(o_in_ready), 64'd0);
      check("t3_hold_valid", 64'(o_out_valid), 64'd1);
      check("t3_hold_a", 64'(o_out_a), 64'h11);
    end
    @(posedge clk); #1;
    i_out_ready = 1'b1;
    e.a = 32'h99; e.b = 32'h11; e.rd = 5'd14; e.we = 1'b0; e.ctrl = 16'h00C3;
    @(negedge clk);
    check("t3_third_accept", 64'(o_in_ready), 64'd1);
    if (o_in_ready) sb.push_back(e);
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    repeat (4) @(posedge clk); #1;

    // Flush kills F and FIFO and releases their busy bits.
    i_out_ready = 1'b0;
    issue(5'd1, 5'd2, 5'd7, 1'b1, 16'h0007, 32'h1001, 32'h1002, 1, "t4_accept_rd7");
    issue(5'd1, 5'd2, 5'd8, 1'b1, 16'h0008, 32'h1001, 32'h1002, 1, "t4_accept_rd8");
    i_flush = 1'b1;
    @(negedge clk);
    check("t4_flush_ready", 64'(o_in_ready), 64'd0);
    @(posedge clk); #1;
    i_flush = 1'b0;
    if (sb.size() >= 2) begin
      void'(sb.pop_back());
      void'(sb.pop_back());
    end
    @(negedge clk);
    check("t4_valid_after_flush", 64'(o_out_valid), 64'd0);
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    issue(5'd7, 5'd8, 5'd9, 1'b0, 16'h0009, 32'h77, 32'h88, 1, "t4_read_r7");
    repeat (4) @(posedge clk); #1;

    // Asynchronous reset while holding output and busy state.
    i_out_ready = 1'b0;
    issue(5'd3, 5'd4, 5'd10, 1'b1, 16'h000A, 32'h11, 32'h22, 1, "t5_accept");
    @(negedge clk);
    @(negedge clk);
    check("t5_valid_before_reset", 64'(o_out_valid), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t5_reset_valid", 64'(o_out_valid), 64'd0);
    check("t5_reset_ready", 64'(o_in_ready), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    i_out_ready = 1'b1;
    issue(5'd10, 5'd3, 5'd10, 1'b1, 16'h000B, 32'hAA, 32'h11, 1, "t5_no_stale_hazard");
    repeat (4) @(posedge clk); #1;

    // Back-to-back throughput.
    n0 = n_out;
    for (int i = 0; i < 10; i++) begin
      i_in_valid = 1'b1; i_in_rs1 = 5'(11 + i); i_in_rs2 = 5'(12 + i);
      i_in_rd = 5'(i + 1); i_in_rd_we = 1'b0; i_in_ctrl = 16'(16'h0100 + i);
      e.a = init_val(11 + i); e.b = init_val(12 + i);
      e.rd = 5'(i + 1); e.we = 1'b0; e.ctrl = 16'(16'h0100 + i);
      @(negedge clk);
      check("t6_ready", 64'(o_in_ready), 64'd1);
      if (o_in_ready) sb.push_back(e);
      @(posedge clk); #1;
    end
    i_in_valid = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("t6_out_count", 64'(n_out - n0), 64'd10);
    if (n0 + 9 < 64)
      check("t6_consecutive", 64'(out_cyc[n0 + 9] - out_cyc[n0]), 64'd9);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage sitting between decode and execute; it is the read-side initiator for the 32x32 register file. It accepts decoded instructions on a valid/ready handshake, drives the register file read addresses, and absorbs the register file's one-cycle registered read latency. It tracks in-flight destination registers in a scoreboard to stall RAW/WAW hazards, bypasses same-cycle writeback data, and delivers operand pairs to execute through a 2-entry output buffer.

## Interface
- DATA_W, 32, operand and writeback data width
- CTRL_W, 16, opaque decoded-control field carried alongside operands
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  decoded instruction offered
- in_ready  output  1  instruction accepted when in_valid && in_ready
- in_rs1, in_rs2  input  5  source register numbers
- in_rd  input  5  destination register number
- in_rd_we  input  1  instruction writes in_rd
- in_ctrl  input  CTRL_W  passthrough control
- r1_add, r2_add  output  5  register file read addresses
- r1_value, r2_value  input  DATA_W  register file read data, valid the cycle after the address is presented
- wb_enable  input  1  writeback strobe (same bus that drives the register file write port)
- wb_add  input  5  writeback register number
- wb_data  input  DATA_W  writeback data
- flush  input  1  synchronous kill of everything held in this block
- out_valid  output  1  operand pair available
- out_ready  input  1  execute accepts when out_valid && out_ready
- out_a, out_b  output  DATA_W  source operands
- out_rd, out_rd_we, out_ctrl  output  5 / 1 / CTRL_W  carried from the instruction

## Operation
- r1_add = in_rs1, r2_add = in_rs2, combinational, every cycle.
- Accept cycle C: instruction captured into stage F (f_valid, rs1, rs2, rd, rd_we, ctrl); the register file samples the addresses at the end of C.
- Cycle C+1: F unconditionally moves into output FIFO (depth 2, in order). out_a = r1_value unless overridden by bypass; same for out_b.
- Bypass: if wb_enable && wb_add==rs1 in cycle C, latch wb_data in F as rs1 override. If wb_enable && wb_add==rs1 in C+1, live wb_data overrides. C+1 takes priority over C. Same for rs2. Register 0 is ordinary (not hardwired).
- Scoreboard busy[31:0]: accept with in_rd_we sets busy[in_rd]; wb_enable clears busy[wb_add]; set wins when both target one register in the same cycle.
- hazard = (busy[in_rs1] && !clr1) || (busy[in_rs2] && !clr2) || (in_rd_we && busy[in_rd] && !clrd), where clrX = wb_enable && wb_add==X.
- in_ready = reset && !flush && !hazard && (occ + f_valid - deq < 2), where occ = FIFO entries and deq = out_valid && out_ready. The combinational out_ready -> in_ready path is intentional.
- flush: F and the FIFO are emptied. For each killed entry with rd_we, busy[rd] is cleared. in_ready = 0 that cycle. Busy bits of instructions already past this block are untouched.
- Reset (asynchronous): out_valid=0, out_a=out_b=0, out_rd=0, out_rd_we=0, out_ctrl=0, f_valid=0, FIFO empty, busy=0, in_ready=0. Asserting reset mid-operation discards all contents immediately.

## Timing
- Latency: accept at cycle C -> out_valid in C+2 when the FIFO is empty.
- Throughput: 1 instruction/cycle with out_ready held high and no hazards.
- Backpressure: with out_ready=0, at most 2 instructions are held (FIFO full, F empty). Release is in order, one per cycle.
- Out fields hold stable while out_valid && !out_ready.

## Configuration
- OPERAND_FETCH_WB_BYPASS_EN defined: the clrX terms are active and bypass muxes are present. A dependent instruction issues in the same cycle its producer's writeback is asserted.
- Not defined: clrX = 0 in the hazard equation and bypass muxes are removed (out_a = r1_value, out_b = r2_value). A dependent instruction issues the cycle after writeback, and the register file read then returns the new value. The scoreboard clear path is unchanged.

## Test plan
- Preload R3=0x11, R4=0x22; issue rs1=3, rs2=4, rd=5 at C -> out_valid at C+2 with out_a=0x11, out_b=0x22, out_rd=5.
- Issue rd=5 (we=1), then rs1=5 -> in_ready=0 until wb_enable with wb_add=5, wb_data=0xDEAD. With macro: accepted that cycle, out_a=0xDEAD. Without macro: accepted one cycle later, out_a=0xDEAD.
- out_ready=0 for 5 cycles, 3 independent instructions offered -> exactly 2 accepted. On out_ready=1 they drain in order over 2 cycles, then the third is accepted.
- F and FIFO hold instructions with rd=7 and rd=8 (we=1); assert flush -> out_valid=0 next cycle, busy[7]=busy[8]=0, and an instruction reading R7 is accepted the following cycle.
- Assert reset while out_valid=1 and busy!=0 -> out_valid=0 and in_ready=0 immediately. After release, in_ready=1 with no stale hazards.
- out_ready=1, 10 independent instructions back-to-back -> 10 accepts in 10 cycles, outputs on consecutive cycles with correct operands.
